// File: rtl/mul_seq_ctrl_if.sv
// Bundle of the request, response and multiplier-cell signals of mul_seq_ctrl.
// Both the request and the response channel use the same valid/ready rule:
// a transfer happens in a cycle where valid && ready are both high. The sender
// holds valid and its payload stable until that cycle. Ready may be high at
// any time.
interface mul_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_result
  );

  // CPU / cell side.
  modport master (
    output req_valid, req_op, req_src1, req_src2, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_result
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for 32x32 Nios-style multiplies on one shared, registered 16x16
// unsigned multiplier cell. It issues the operand half pairs LL, LH, HL, HH,
// accumulates the shifted partial products into 64 bits, and then corrects
// the high word for signed operands.
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  mul_seq_ctrl_if.slave      bus,
  output logic [2:0]         dbg_state
);

  localparam int L = MUL_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FIX   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Shift codes carried with each partial product: 0 -> 0, 1 -> 16, 2 -> 32.
  function automatic logic [33:0] pick_pair(input logic [1:0]  idx,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (idx)
      2'd0:    return {2'd0, a[15:0],  b[15:0]};
      2'd1:    return {2'd1, a[15:0],  b[31:16]};
      2'd2:    return {2'd1, a[31:16], b[15:0]};
      default: return {2'd2, a[31:16], b[31:16]};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        mul_en_q, mul_en_d;
  logic [15:0] mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic [63:0] acc_q, acc_d;
  // Tag of the pair currently on mul_a/mul_b; it enters the tag pipe when the
  // cell advances.
  logic        cur_vld_q, cur_vld_d;
  logic [1:0]  cur_sh_q, cur_sh_d;
  logic        tag_vld_q [L];
  logic        tag_vld_d [L];
  logic [1:0]  tag_sh_q  [L];
  logic [1:0]  tag_sh_d  [L];

  logic        accept;
  logic [2:0]  n_pairs;
  logic [33:0] next_pair;
  logic [63:0] p_shifted;
  logic [31:0] acc_hi;
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  assign bus.req_ready  = req_ready_q && !reset;
  assign bus.mul_en     = mul_en_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign dbg_state      = state_q;

  assign accept    = bus.req_valid && bus.req_ready;
  // MUL only needs the low word, so the HH pair is never issued for it.
  assign n_pairs   = (op_q == 2'b00) ? 3'd3 : 3'd4;
  assign next_pair = pick_pair(idx_q[1:0], a_q, b_q);
  assign acc_hi    = acc_q[63:32];
  assign corr_a    = a_q[31] ? b_q : 32'd0;
  assign corr_b    = b_q[31] ? a_q : 32'd0;

  // Align the product leaving the cell according to the tag leaving the pipe.
  always_comb begin
    p_shifted = '0;
    case (tag_sh_q[L-1])
      2'd0:    p_shifted = {32'd0, bus.mul_p};
      2'd1:    p_shifted = {16'd0, bus.mul_p, 16'd0};
      default: p_shifted = {bus.mul_p, 32'd0};
    endcase
  end

  // Next-state logic: tag pipe, accumulator and the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    mul_en_d     = mul_en_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    idx_d        = idx_q;
    drain_cnt_d  = drain_cnt_q;
    acc_d        = acc_q;
    cur_vld_d    = cur_vld_q;
    cur_sh_d     = cur_sh_q;
    for (int i = 0; i < L; i++) begin
      tag_vld_d[i] = tag_vld_q[i];
      tag_sh_d[i]  = tag_sh_q[i];
    end

    // Tags move in lockstep with the cell pipeline, which only advances on mul_en.
    if (mul_en_q) begin
      tag_vld_d[0] = cur_vld_q;
      tag_sh_d[0]  = cur_sh_q;
      for (int i = 1; i < L; i++) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_sh_d[i]  = tag_sh_q[i-1];
      end
      if (tag_vld_q[L-1]) acc_d = acc_q + p_shifted;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d        = bus.req_op;
          a_d         = bus.req_src1;
          b_d         = bus.req_src2;
          acc_d       = '0;
          req_ready_d = 1'b0;
          mul_en_d    = 1'b1;
          {cur_sh_d, mul_a_d, mul_b_d} = pick_pair(2'd0, bus.req_src1, bus.req_src2);
          cur_vld_d   = 1'b1;
          idx_d       = 3'd1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (idx_q == n_pairs) begin
          mul_a_d     = '0;
          mul_b_d     = '0;
          cur_vld_d   = 1'b0;
          cur_sh_d    = 2'd0;
          drain_cnt_d = 2'd0;
          state_d     = S_DRAIN;
        end else begin
          {cur_sh_d, mul_a_d, mul_b_d} = next_pair;
          cur_vld_d = 1'b1;
          idx_d     = idx_q + 3'd1;
        end
      end
      S_DRAIN: begin
        // The last issued tag leaves the pipe in the final drain cycle.
        if (drain_cnt_q == 2'(L - 1)) begin
          mul_en_d = 1'b0;
          state_d  = S_FIX;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      S_FIX: begin
        case (op_q)
          2'b00:   rsp_result_d = acc_q[31:0];
          2'b01:   rsp_result_d = acc_hi - corr_a - corr_b;
          2'b10:   rsp_result_d = acc_hi - corr_a;
          default: rsp_result_d = acc_hi;
        endcase
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        mul_en_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      mul_en_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      drain_cnt_q  <= '0;
      acc_q        <= '0;
      cur_vld_q    <= 1'b0;
      cur_sh_q     <= '0;
      for (int i = 0; i < L; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_sh_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      mul_en_q     <= mul_en_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      idx_q        <= idx_d;
      drain_cnt_q  <= drain_cnt_d;
      acc_q        <= acc_d;
      cur_vld_q    <= cur_vld_d;
      cur_sh_q     <= cur_sh_d;
      for (int i = 0; i < L; i++) begin
        tag_vld_q[i] <= tag_vld_d[i];
        tag_sh_q[i]  <= tag_sh_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: one instance with MUL_LATENCY=1 and one with 3, each
// driving its own behavioural 16x16 cell. Results are compared against 64-bit
// reference products computed directly from the operands.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Clock
  always #5 clk = ~clk;

  mul_seq_ctrl_if bus1 ();
  mul_seq_ctrl_if bus3 ();
  logic [2:0] dbg1, dbg3;

  mul_seq_ctrl #(.MUL_LATENCY(1)) u_l1 (.clk(clk), .reset(rst), .bus(bus1), .dbg_state(dbg1));
  mul_seq_ctrl #(.MUL_LATENCY(3)) u_l3 (.clk(clk), .reset(rst), .bus(bus3), .dbg_state(dbg3));

  // Multiplier cells: registered pipelines that advance only on mul_en.
  logic [31:0] cell1_q = '0;
  logic [31:0] cell3_q [3] = '{32'd0, 32'd0, 32'd0};
  always @(posedge clk) if (bus1.mul_en) cell1_q <= 32'(bus1.mul_a) * 32'(bus1.mul_b);
  always @(posedge clk) begin
    if (bus3.mul_en) begin
      cell3_q[0] <= 32'(bus3.mul_a) * 32'(bus3.mul_b);
      cell3_q[1] <= cell3_q[0];
      cell3_q[2] <= cell3_q[1];
    end
  end
  assign bus1.mul_p = cell1_q;
  assign bus3.mul_p = cell3_q[2];

  // Drivers, index 0 -> latency-1 instance, index 1 -> latency-3 instance.
  logic [1:0]  drv_valid;
  logic [1:0]  drv_rspr;
  logic [1:0]  drv_op [2];
  logic [31:0] drv_a  [2];
  logic [31:0] drv_b  [2];

  assign bus1.req_valid = drv_valid[0];
  assign bus1.req_op    = drv_op[0];
  assign bus1.req_src1  = drv_a[0];
  assign bus1.req_src2  = drv_b[0];
  assign bus1.rsp_ready = drv_rspr[0];
  assign bus3.req_valid = drv_valid[1];
  assign bus3.req_op    = drv_op[1];
  assign bus3.req_src1  = drv_a[1];
  assign bus3.req_src2  = drv_b[1];
  assign bus3.rsp_ready = drv_rspr[1];

  wire [1:0]  o_rdy = {bus3.req_ready, bus1.req_ready};
  wire [1:0]  o_vld = {bus3.rsp_valid, bus1.rsp_valid};
  wire [1:0]  o_en  = {bus3.mul_en,    bus1.mul_en};
  wire [31:0] o_res [2];
  wire [31:0] o_ab  [2];
  assign o_res[0] = bus1.rsp_result;
  assign o_res[1] = bus3.rsp_result;
  assign o_ab[0]  = {bus1.mul_a, bus1.mul_b};
  assign o_ab[1]  = {bus3.mul_a, bus3.mul_b};

  // Directed table: MUL 3x5, MUL/MULXUU 0x12345 x 0x10000, all-ones cases.
  logic [1:0]  t_op  [6] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2};
  logic [31:0] t_a   [6] = '{32'h3, 32'h12345, 32'h12345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_b   [6] = '{32'h5, 32'h10000, 32'h10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_exp [6] = '{32'hF, 32'h23450000, 32'h1, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF};

  // Reference: full-width products taken with the signedness each op names.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        uu;
    logic signed [63:0] sa, sb, ub, ss, su;
    uu = {32'd0, a} * {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ss = sa * sb;
    su = sa * ub;
    case (op)
      2'd0:    return uu[31:0];
      2'd1:    return ss[63:32];
      2'd2:    return su[63:32];
      default: return uu[63:32];
    endcase
  endfunction

  function automatic int n_of(input logic [1:0] op);
    return (op == 2'd0) ? 3 : 4;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    drv_valid[sel] = v;
    drv_op[sel]    = op;
    drv_a[sel]     = a;
    drv_b[sel]     = b;
  endtask

  // Drive one request with rsp_ready high; report result, latency in cycles
  // after the accept cycle, and how many cycles mul_en was high.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int en_cnt);
    int w;
    bit seen;
    res = '0; lat = -1; en_cnt = 0; seen = 1'b0; w = 0;
    @(negedge clk);
    set_req(sel, 1'b1, op, a, b);
    while (!o_rdy[sel] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!o_rdy[sel]) begin
      checks++; errors++;
      $display("FAIL accept_timeout sel=%0d got req_ready=0 want 1", sel);
      set_req(sel, 1'b0, op, a, b);
      return;
    end
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (o_en[sel]) en_cnt++;
      if (o_vld[sel]) begin
        seen = 1'b1;
        res  = o_res[sel];
        lat  = k;
        set_req(sel, 1'b0, op, a, b);
      end else begin
        // Noise on the request side while busy must be ignored.
        set_req(sel, 1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL rsp_timeout sel=%0d got rsp_valid=0 want 1", sel);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (o_rdy[s] !== 1'b0) begin errors++; $display("FAIL reset_req_ready sel=%0d got %b want 0", s, o_rdy[s]); end
      checks++;
      if (o_vld[s] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid sel=%0d got %b want 0", s, o_vld[s]); end
      checks++;
      if (o_en[s] !== 1'b0) begin errors++; $display("FAIL reset_mul_en sel=%0d got %b want 0", s, o_en[s]); end
      checks++;
      if (o_ab[s] !== 32'd0) begin errors++; $display("FAIL reset_mul_ab sel=%0d got %h want 0", s, o_ab[s]); end
      checks++;
      if (o_res[s] !== 32'd0) begin errors++; $display("FAIL reset_result sel=%0d got %h want 0", s, o_res[s]); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (o_rdy[s] !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready sel=%0d got %b want 1", s, o_rdy[s]); end
    end
  endtask

  task automatic test_directed(input int sel);
    logic [31:0] res;
    int lat, en_cnt, lw;
    lw = (sel == 0) ? 1 : 3;
    for (int i = 0; i < 6; i++) begin
      run_op(sel, t_op[i], t_a[i], t_b[i], res, lat, en_cnt);
      checks++;
      if (res !== t_exp[i]) begin errors++; $display("FAIL dir_result sel=%0d idx=%0d got %h want %h", sel, i, res, t_exp[i]); end
      checks++;
      if (lat != n_of(t_op[i]) + lw + 2) begin errors++; $display("FAIL dir_latency sel=%0d idx=%0d got %0d want %0d", sel, i, lat, n_of(t_op[i]) + lw + 2); end
      checks++;
      if (en_cnt != n_of(t_op[i]) + lw) begin errors++; $display("FAIL dir_mul_en sel=%0d idx=%0d got %0d want %0d", sel, i, en_cnt, n_of(t_op[i]) + lw); end
    end
  endtask

  task automatic test_random(input int sel, input int count);
    logic [31:0] res, a, b, exp;
    logic [1:0]  op;
    int lat, en_cnt, lw;
    lw = (sel == 0) ? 1 : 3;
    for (int i = 0; i < count; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h80000000;
        1:       b = 32'd0;
        default: b = $urandom;
      endcase
      exp = ref_mul(op, a, b);
      run_op(sel, op, a, b, res, lat, en_cnt);
      checks++;
      if (res !== exp) begin errors++; $display("FAIL rand_result sel=%0d op=%0d a=%h b=%h got %h want %h", sel, op, a, b, res, exp); end
      checks++;
      if (lat != n_of(op) + lw + 2) begin errors++; $display("FAIL rand_latency sel=%0d op=%0d got %0d want %0d", sel, op, lat, n_of(op) + lw + 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    int  k, w;
    bit  seen;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_mul(2'd1, a1, b1);
    e2 = ref_mul(2'd0, a2, b2);
    drv_rspr[0] = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 2'd1, a1, b1);
    w = 0;
    while (!o_rdy[0] && w < 50) begin @(negedge clk); w++; end
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (o_vld[0]) seen = 1'b1;
      else set_req(0, 1'b0, 2'd1, a1, b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_rsp_timeout got rsp_valid=0 want 1");
      drv_rspr[0] = 1'b1;
      return;
    end
    checks++;
    if (o_res[0] !== e1) begin errors++; $display("FAIL bp_result1 got %h want %h", o_res[0], e1); end
    checks++;
    if (k != 7) begin errors++; $display("FAIL bp_latency1 got %0d want 7", k); end
    // Second request waits while the first response is stalled.
    set_req(0, 1'b1, 2'd0, a2, b2);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (o_vld[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", s, o_vld[0]); end
      checks++;
      if (o_res[0] !== e1) begin errors++; $display("FAIL bp_hold_result cyc=%0d got %h want %h", s, o_res[0], e1); end
      checks++;
      if (o_rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc=%0d got %b want 0", s, o_rdy[0]); end
    end
    drv_rspr[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL bp_after_hs_valid got %b want 0", o_vld[0]); end
    checks++;
    if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_after_hs_ready got %b want 1", o_rdy[0]); end
    seen = 1'b0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      set_req(0, 1'b0, 2'd0, a2, b2);
      if (o_vld[0]) seen = 1'b1;
    end
    checks++;
    if (!seen || o_res[0] !== e2) begin errors++; $display("FAIL bp_result2 got %h want %h", o_res[0], e2); end
    checks++;
    if (k != 6) begin errors++; $display("FAIL bp_latency2 got %0d want 6", k); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, en_cnt, w;
    @(negedge clk);
    set_req(0, 1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    w = 0;
    while (!o_rdy[0] && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    set_req(0, 1'b0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_en[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_mul_en got %b want 0", o_en[0]); end
    checks++;
    if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid got %b want 0", o_vld[0]); end
    checks++;
    if (o_ab[0] !== 32'd0) begin errors++; $display("FAIL rst_mid_mul_ab got %h want 0", o_ab[0]); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready got %b want 1", o_rdy[0]); end
    run_op(0, 2'd0, 32'd7, 32'd6, res, lat, en_cnt);
    checks++;
    if (res !== 32'h2A) begin errors++; $display("FAIL rst_mid_result got %h want 0000002a", res); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL rst_mid_latency got %0d want 6", lat); end
  endtask

  initial begin
    drv_valid = 2'b00;
    drv_rspr  = 2'b11;
    for (int s = 0; s < 2; s++) begin
      drv_op[s] = 2'd0; drv_a[s] = '0; drv_b[s] = '0;
    end
    test_reset();
    test_directed(0);
    test_directed(1);
    test_backpressure();
    test_reset_mid();
    test_random(0, 30);
    test_random(1, 30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
